// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 keyboard port.
//   rx_state_t     frame receiver FSM states
//   SC_BREAK/EXT   set-2 prefix bytes that modify the following code
//   scan_to_ascii  set-2 make code -> {hit, ascii[6:0]}; hit=0 for unmapped codes
package kbd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } rx_state_t;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
      logic [7:0] r;
      r = 8'h00;
      case (code)
         8'h1C: r = {1'b1, 7'h41}; // A
         8'h32: r = {1'b1, 7'h42}; // B
         8'h21: r = {1'b1, 7'h43}; // C
         8'h23: r = {1'b1, 7'h44}; // D
         8'h24: r = {1'b1, 7'h45}; // E
         8'h2B: r = {1'b1, 7'h46}; // F
         8'h34: r = {1'b1, 7'h47}; // G
         8'h33: r = {1'b1, 7'h48}; // H
         8'h43: r = {1'b1, 7'h49}; // I
         8'h3B: r = {1'b1, 7'h4A}; // J
         8'h42: r = {1'b1, 7'h4B}; // K
         8'h4B: r = {1'b1, 7'h4C}; // L
         8'h3A: r = {1'b1, 7'h4D}; // M
         8'h31: r = {1'b1, 7'h4E}; // N
         8'h44: r = {1'b1, 7'h4F}; // O
         8'h4D: r = {1'b1, 7'h50}; // P
         8'h15: r = {1'b1, 7'h51}; // Q
         8'h2D: r = {1'b1, 7'h52}; // R
         8'h1B: r = {1'b1, 7'h53}; // S
         8'h2C: r = {1'b1, 7'h54}; // T
         8'h3C: r = {1'b1, 7'h55}; // U
         8'h2A: r = {1'b1, 7'h56}; // V
         8'h1D: r = {1'b1, 7'h57}; // W
         8'h22: r = {1'b1, 7'h58}; // X
         8'h35: r = {1'b1, 7'h59}; // Y
         8'h1A: r = {1'b1, 7'h5A}; // Z
         8'h45: r = {1'b1, 7'h30}; // 0
         8'h16: r = {1'b1, 7'h31}; // 1
         8'h1E: r = {1'b1, 7'h32}; // 2
         8'h26: r = {1'b1, 7'h33}; // 3
         8'h25: r = {1'b1, 7'h34}; // 4
         8'h2E: r = {1'b1, 7'h35}; // 5
         8'h36: r = {1'b1, 7'h36}; // 6
         8'h3D: r = {1'b1, 7'h37}; // 7
         8'h3E: r = {1'b1, 7'h38}; // 8
         8'h46: r = {1'b1, 7'h39}; // 9
         8'h29: r = {1'b1, 7'h20}; // space
         8'h5A: r = {1'b1, 7'h0D}; // enter
         8'h66: r = {1'b1, 7'h08}; // backspace
         8'h76: r = {1'b1, 7'h1B}; // esc
         default: r = 8'h00;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
//   clk, reset      system clock, synchronous active-high reset
//   i_ps2_clk/data  raw asynchronous PS/2 lines
//   o_byte          received data byte (stable while o_byte_valid is high)
//   o_byte_valid    1-cycle pulse on a frame with good start, parity and stop
//   o_frame_err     1-cycle pulse on parity/stop error or inter-edge timeout
//
// Handshake: o_byte_valid is a plain 1-cycle strobe with no ready; the
// consumer must take o_byte in that cycle.
module ps2_frame_rx
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_byte,
   output logic       o_byte_valid,
   output logic       o_frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   // Lines idle high, so the sync chain resets to 1 to avoid a false fall.
   logic r_clk_s1, r_clk_s2, r_clk_s3;
   logic r_data_s1, r_data_s2;

   rx_state_t       r_state, w_state_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [TW-1:0]   r_timer, w_timer_nxt;
   logic            r_byte_valid, w_byte_valid_nxt;
   logic            r_frame_err, w_frame_err_nxt;

   logic            w_fall;
   logic            w_data;

   assign w_fall = r_clk_s3 & ~r_clk_s2;
   assign w_data = r_data_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1  <= 1'b1;
         r_clk_s2  <= 1'b1;
         r_clk_s3  <= 1'b1;
         r_data_s1 <= 1'b1;
         r_data_s2 <= 1'b1;
      end else begin
         r_clk_s1  <= i_ps2_clk;
         r_clk_s2  <= r_clk_s1;
         r_clk_s3  <= r_clk_s2;
         r_data_s1 <= i_ps2_data;
         r_data_s2 <= r_data_s1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_shift      <= 8'h00;
         r_bit_cnt    <= 3'd0;
         r_timer      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_shift      <= w_shift_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_timer      <= w_timer_nxt;
         r_byte_valid <= w_byte_valid_nxt;
         r_frame_err  <= w_frame_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_nxt      = r_shift;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_byte_valid_nxt = 1'b0;
      w_frame_err_nxt  = 1'b0;
      // Timer only runs mid-frame and restarts on every falling edge.
      w_timer_nxt      = (r_state == ST_IDLE || w_fall) ? '0 : r_timer + TW'(1);

      if (r_state != ST_IDLE && r_timer == TW'(TIMEOUT_CYCLES)) begin
         w_state_nxt     = ST_IDLE;
         w_frame_err_nxt = 1'b1;
         w_timer_nxt     = '0;
      end else if (w_fall) begin
         case (r_state)
            ST_IDLE: begin
               // A high level at the first fall is not a start bit.
               if (!w_data) begin
                  w_state_nxt   = ST_SHIFT;
                  w_bit_cnt_nxt = 3'd0;
               end
            end
            ST_SHIFT: begin
               w_shift_nxt = {w_data, r_shift[7:1]};
               if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
               else                   w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
            ST_PARITY: begin
               // Odd parity: data plus parity bit must hold an odd number of ones.
               if (^{r_shift, w_data}) begin
                  w_state_nxt = ST_STOP;
               end else begin
                  w_state_nxt     = ST_IDLE;
                  w_frame_err_nxt = 1'b1;
               end
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (w_data) w_byte_valid_nxt = 1'b1;
               else        w_frame_err_nxt  = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign o_byte       = r_shift;
   assign o_byte_valid = r_byte_valid;
   assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_keyboard_port.sv
// ps2_keyboard_port: PS/2 keyboard front end for the CPU16 key input.
//   clk, reset   system clock, synchronous active-high reset
//   ps2_clk/data raw PS/2 connector lines (asynchronous)
//   keystrobe    CPU acknowledge; a rising edge pops the FIFO head
//   keycode      {fifo_not_empty, head_ascii[6:0]}, 8'h00 when empty
//   frame_err    1-cycle pulse on a receive error or timeout
//   overflow     sticky flag: a character was dropped on a full FIFO
//
// Handshake: keycode[7] acts as valid; a keystrobe rising edge is the
// ready/ack and consumes exactly one entry. The next head appears on
// keycode one clock after the edge is sampled.
module ps2_keyboard_port
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       keystrobe,
   output logic [7:0] keycode,
   output logic       frame_err,
   output logic       overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0] w_byte;
   logic       w_byte_valid;
   logic       w_frame_err;
   logic [7:0] w_map;

   ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .i_ps2_clk    (ps2_clk),
      .i_ps2_data   (ps2_data),
      .o_byte       (w_byte),
      .o_byte_valid (w_byte_valid),
      .o_frame_err  (w_frame_err)
   );

   // Break/extended filter and ASCII decode register.
   logic       r_brk, r_ext;
   logic       r_dec_valid;
   logic [6:0] r_dec_char;

   assign w_map = scan_to_ascii(w_byte);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_brk       <= 1'b0;
         r_ext       <= 1'b0;
         r_dec_valid <= 1'b0;
         r_dec_char  <= 7'h00;
      end else begin
         r_dec_valid <= 1'b0;
         if (w_byte_valid) begin
            if (w_byte == SC_BREAK) begin
               r_brk <= 1'b1;
            end else if (w_byte == SC_EXT) begin
               r_ext <= 1'b1;
            end else if (r_brk | r_ext) begin
               // Byte following a prefix is a release or extended key: swallow it.
               r_brk <= 1'b0;
               r_ext <= 1'b0;
            end else begin
               r_dec_valid <= w_map[7];
               r_dec_char  <= w_map[6:0];
            end
         end
      end
   end

   // Character FIFO.
   logic [6:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
   logic [AW:0]   r_count, w_count_nxt;
   logic          r_ks_q;
   logic [7:0]    r_keycode, w_keycode_nxt;
   logic          r_overflow;
   logic          w_full, w_empty, w_pop, w_push, w_drop;
   logic [6:0]    w_head_nxt;

   always_comb begin
      w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
      w_empty = (r_count == '0);
      w_pop   = keystrobe & ~r_ks_q & ~w_empty;
      // A same-cycle pop frees a slot, so a full FIFO can still accept.
      w_push  = r_dec_valid & (~w_full | w_pop);
      w_drop  = r_dec_valid & w_full & ~w_pop;
      w_rd_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + (AW+1)'(1);
         2'b01:   w_count_nxt = r_count - (AW+1)'(1);
         default: w_count_nxt = r_count;
      endcase
      // keycode is registered from the post-update head; when the new head is
      // the slot being written this cycle, bypass the incoming character.
      if (w_push && w_rd_nxt == r_wr_ptr) w_head_nxt = r_dec_char;
      else                                w_head_nxt = r_mem[w_rd_nxt];
      w_keycode_nxt = (w_count_nxt != '0) ? {1'b1, w_head_nxt} : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= r_dec_char;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_ks_q     <= 1'b0;
         r_keycode  <= 8'h00;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr   <= w_rd_nxt;
         r_count    <= w_count_nxt;
         r_ks_q     <= keystrobe;
         r_keycode  <= w_keycode_nxt;
         r_overflow <= r_overflow | w_drop;
      end
   end

   assign keycode   = r_keycode;
   assign frame_err = w_frame_err;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_keyboard_port.sv
module tb_ps2_keyboard_port;

  localparam int DEPTH = 4;
  localparam int TMO   = 400;
  localparam int HALF  = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data, keystrobe;
  logic [7:0] keycode;
  logic frame_err, overflow;

  always #5 clk = ~clk;

  ps2_keyboard_port #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keystrobe (keystrobe),
    .keycode   (keycode),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // ---------------- reference model ----------------
  logic [7:0] exp_q[$];
  int n_cmp = 0, n_fail = 0;
  int n_push = 0, n_pops = 0;
  int err_cnt = 0, exp_err = 0;
  bit m_brk = 0, m_ext = 0, m_ovf = 0;
  bit ghost_rep = 0;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46};
  logic [7:0] spec_sc [4] = '{8'h29, 8'h5A, 8'h66, 8'h76};
  logic [7:0] spec_ch [4] = '{8'h20, 8'h0D, 8'h08, 8'h1B};

  // {hit, ascii}: letters and digits by table position, plus the four specials
  function automatic logic [7:0] ref_ascii(input logic [7:0] sc);
    logic [7:0] a;
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == sc) begin a = 8'h41 + 8'(i); return {1'b1, a[6:0]}; end
    for (int i = 0; i < 10; i++)
      if (digit_sc[i] == sc) begin a = 8'h30 + 8'(i); return {1'b1, a[6:0]}; end
    for (int i = 0; i < 4; i++)
      if (spec_sc[i] == sc) begin a = spec_ch[i]; return {1'b1, a[6:0]}; end
    return 8'h00;
  endfunction

  function automatic logic [7:0] pick_mapped();
    int r;
    r = $urandom_range(0, 39);
    if (r < 26) return letter_sc[r];
    if (r < 36) return digit_sc[r-26];
    return spec_sc[r-36];
  endfunction

  task automatic model_good_frame(input logic [7:0] code, input bit simul_pop);
    logic [7:0] r;
    if (code == 8'hF0) m_brk = 1;
    else if (code == 8'hE0) m_ext = 1;
    else if (m_brk || m_ext) begin m_brk = 0; m_ext = 0; end
    else begin
      r = ref_ascii(code);
      if (r[7]) begin
        if ((n_push - n_pops) < DEPTH || simul_pop) begin
          exp_q.push_back({1'b1, r[6:0]});
          n_push++;
        end else m_ovf = 1;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    n_push = n_pops;
    m_brk = 0; m_ext = 0; m_ovf = 0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nfalls=11 sends a full frame; fewer sends a truncated one.
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nfalls,
                            input bit ks_at_stop);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nfalls; i++) begin
      ps2_data = bits[i];
      step(HALF);
      ps2_clk = 1'b0;
      if (i == 9 && bad_par) exp_err++;
      if (i == 10 && !bad_par) model_good_frame(code, ks_at_stop);
      if (i == 10 && ks_at_stop) begin
        // Raise the ack so its edge lands on the same clock as the FIFO write.
        step(4);
        keystrobe = 1'b1;
        step(HALF - 4);
      end else step(HALF);
      ps2_clk = 1'b1;
    end
    keystrobe = 1'b0;
    ps2_data = 1'b1;
    step(HALF);
  endtask

  task automatic pulse_ks(input int hi);
    keystrobe = 1'b1;
    step(hi);
    keystrobe = 1'b0;
    step(2);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && keycode[7]; k++) pulse_ks(1);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic monitor();
    logic ks_prev, err_prev;
    logic [7:0] e;
    ks_prev = 1'b0; err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ks_prev = keystrobe;
        err_prev = 1'b0;
      end else begin
        if (keystrobe && !ks_prev && keycode[7]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL pop_unexpected: got %02h expected no entry at %0t", keycode, $time);
          end else begin
            e = exp_q.pop_front();
            check("pop_head", keycode, e);
            n_pops++;
          end
        end else if (keycode[7] && exp_q.size() == 0 && !ghost_rep) begin
          ghost_rep = 1;
          n_cmp++; n_fail++;
          $display("FAIL ghost_entry: got %02h expected 00 at %0t", keycode, $time);
        end
        if (frame_err) begin
          if (err_prev) begin
            n_cmp++; n_fail++;
            $display("FAIL frame_err_width: got 2+ cycles expected 1 at %0t", $time);
          end else err_cnt++;
        end
        ks_prev = keystrobe;
        err_prev = frame_err;
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got no finish expected finish by 800us");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; keystrobe = 1'b0;
    fork monitor(); join_none
    step(5);
    reset = 1'b0;
    step(2);
    check("reset_keycode", keycode, 8'h00);
    check("reset_frame_err", {7'h0, frame_err}, 8'h00);
    check("reset_overflow", {7'h0, overflow}, 8'h00);

    // 1: space
    send_frame(8'h29, 0, 11, 0);
    check("space_keycode", keycode, 8'hA0);
    check("space_no_err", 8'(err_cnt), 8'(exp_err));

    // 2: break of space adds nothing; pop empties
    send_frame(8'hF0, 0, 11, 0);
    send_frame(8'h29, 0, 11, 0);
    check("break_no_entry", keycode, 8'hA0);
    pulse_ks(1);
    check("empty_after_pop", keycode, 8'h00);

    // 3: overflow
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'h32, 0, 11, 0);
    send_frame(8'h21, 0, 11, 0);
    send_frame(8'h23, 0, 11, 0);
    send_frame(8'h24, 0, 11, 0);
    check("overflow_set", {7'h0, overflow}, {7'h0, m_ovf});
    for (int k = 0; k < DEPTH; k++) pulse_ks(1);
    check("drained_keycode", keycode, 8'h00);
    pulse_ks(2); // keystrobe while empty: no effect

    // 4: bad parity, then good frame
    send_frame(8'h1C, 1, 11, 0);
    check("parity_err_count", 8'(err_cnt), 8'(exp_err));
    check("parity_no_entry", keycode, 8'h00);
    send_frame(8'h1C, 0, 11, 0);
    check("after_parity_keycode", keycode, 8'hC1);
    pulse_ks(1);

    // 5: truncated frame times out
    send_frame(8'h45, 0, 5, 0);
    exp_err++;
    step(TMO + 50);
    check("timeout_err_count", 8'(err_cnt), 8'(exp_err));
    send_frame(8'h45, 0, 11, 0);
    check("after_timeout_keycode", keycode, 8'hB0);
    pulse_ks(1);

    // 6a: held keystrobe pops once
    send_frame(8'h1C, 0, 11, 0);
    send_frame(8'h32, 0, 11, 0);
    pulse_ks(10);
    check("held_ks_one_pop", keycode, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
    drain();

    // 6b: reset mid-frame
    send_frame(8'h21, 0, 4, 0);
    reset = 1'b1;
    step(2);
    model_reset();
    reset = 1'b0;
    step(1);
    check("midreset_keycode", keycode, 8'h00);
    check("midreset_frame_err", {7'h0, frame_err}, 8'h00);
    check("midreset_overflow", {7'h0, overflow}, 8'h00);
    send_frame(8'h1C, 0, 11, 0);
    check("post_reset_keycode", keycode, 8'hC1);
    drain();

    // 6c: push into full FIFO with a same-cycle pop
    send_frame(8'h21, 0, 11, 0);
    send_frame(8'h23, 0, 11, 0);
    send_frame(8'h24, 0, 11, 0);
    send_frame(8'h2B, 0, 11, 0);
    send_frame(8'h34, 0, 11, 1);
    check("simul_no_overflow", {7'h0, overflow}, 8'h00);
    check("simul_head", keycode, 8'hC4);
    drain();
    check("simul_all_popped", 8'(exp_q.size()), 8'h00);

    // 7: random traffic
    for (int f = 0; f < 40; f++) begin
      int sel;
      logic [7:0] code;
      sel = $urandom_range(0, 9);
      if (sel < 7) code = pick_mapped();
      else if (sel == 7) code = 8'hF0;
      else if (sel == 8) code = 8'hE0;
      else code = 8'($urandom_range(0, 255));
      send_frame(code, 0, 11, 0);
      repeat ($urandom_range(0, 2)) pulse_ks($urandom_range(1, 3));
    end
    check("rand_overflow", {7'h0, overflow}, {7'h0, m_ovf});
    drain();
    check("rand_queue_empty", 8'(exp_q.size()), 8'h00);
    check("rand_keycode_empty", keycode, 8'h00);
    check("final_err_count", 8'(err_cnt), 8'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
